// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the tone/envelope synthesiser stage:
//   - SAMPLE_W     : width of the signed audio sample
//   - HP_W         : width of a note half-period / tone counter
//   - hp_tab_t     : packed table of four half-periods, index 0 = leftmost button
//   - NOTE_HP      : default half-periods (clk cycles) for notes 0..3
//   - env_state_t  : envelope state encoding
//   - note_encode  : priority encoder, buttons[3] has the highest priority
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int HP_W     = 17;

    typedef logic [3:0][HP_W-1:0] hp_tab_t;

    // Index 0 is the rightmost element of the concatenation.
    localparam hp_tab_t NOTE_HP = {17'd45097, 17'd50621, 17'd60199, 17'd75844};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_t;

    // Priority encode the button columns into a note index.
    function automatic logic [1:0] note_encode(input logic [3:0] btn);
        logic [1:0] idx;
        if (btn[3]) begin
            idx = 2'd0;
        end else if (btn[2]) begin
            idx = 2'd1;
        end else if (btn[1]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/tone_envelope_gen_if.sv
// -----------------------------------------------------------------------------
// tone_envelope_gen_if
// Groups the button/tick inputs and the sample outputs of tone_envelope_gen.
//   buttons       : synchronised column buttons, active high, [3] = leftmost
//   sample_tick   : one-clk strobe per output sample
//   audio_sample  : signed sample to the codec
//   sample_valid  : one-clk pulse, audio_sample updated this cycle
//   busy          : envelope is not idle
// master = stimulus side, slave = tone_envelope_gen.
// -----------------------------------------------------------------------------
interface tone_envelope_gen_if;
    import audio_pkg::*;

    logic [3:0]          buttons;
    logic                sample_tick;
    logic [SAMPLE_W-1:0] audio_sample;
    logic                sample_valid;
    logic                busy;

    modport master (
        output buttons,
        output sample_tick,
        input  audio_sample,
        input  sample_valid,
        input  busy
    );

    modport slave (
        input  buttons,
        input  sample_tick,
        output audio_sample,
        output sample_valid,
        output busy
    );

endinterface

// File: rtl/note_tone_osc.sv
// -----------------------------------------------------------------------------
// note_tone_osc
// Square-wave oscillator. The counter runs while i_run is high and wraps when
// it reaches the half-period of the selected note, toggling the tone, so one
// tone level lasts half_period+1 clk. A note change keeps the current count;
// the >= compare wraps at once if the count already exceeds the new period.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_note       : note index 0..3
//   i_run        : oscillator enable; low forces counter=0 and tone=0
//   o_tone       : registered square-wave level
// -----------------------------------------------------------------------------
module note_tone_osc
    import audio_pkg::*;
#(
    parameter hp_tab_t HALF_PERIODS = NOTE_HP
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_note,
    input  logic       i_run,
    output logic       o_tone
);

    logic [HP_W-1:0] r_cnt;
    logic            r_tone;
    logic [HP_W-1:0] w_hp;
    logic            w_wrap;

    assign w_hp   = HALF_PERIODS[i_note];
    assign w_wrap = (r_cnt >= w_hp);
    assign o_tone = r_tone;

    // Tone counter and square-wave level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= {HP_W{1'b0}};
            r_tone <= 1'b0;
        end else if (!i_run) begin
            r_cnt  <= {HP_W{1'b0}};
            r_tone <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= {HP_W{1'b0}};
            r_tone <= ~r_tone;
        end else begin
            r_cnt  <= r_cnt + {{(HP_W-1){1'b0}}, 1'b1};
            r_tone <= r_tone;
        end
    end

endmodule

// File: rtl/tone_envelope_gen.sv
// -----------------------------------------------------------------------------
// tone_envelope_gen
// Note synthesiser stage feeding the codec sample input. Buttons select a note
// (priority encoder), note_tone_osc produces the square tone, and a linear
// attack/sustain/release envelope scales it. One signed sample is produced per
// sample_tick, one clk after the tick.
// Ports:
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   bus (slave)  : buttons, sample_tick in; audio_sample, sample_valid, busy out
// -----------------------------------------------------------------------------
module tone_envelope_gen
    import audio_pkg::*;
#(
    parameter logic [15:0] AMP_MAX      = 16'h4000,
    parameter logic [15:0] ATTACK_STEP  = 16'd64,
    parameter logic [15:0] RELEASE_STEP = 16'd32,
    parameter hp_tab_t     HALF_PERIODS = NOTE_HP
) (
    input  logic                clk,
    input  logic                reset_n,
    tone_envelope_gen_if.slave  bus
);

    env_state_t          r_state;
    env_state_t          w_state_next;
    logic [15:0]         r_amp;
    logic [15:0]         w_amp_next;
    logic [1:0]          r_note;
    logic                r_busy;
    logic [SAMPLE_W-1:0] r_sample;
    logic [SAMPLE_W-1:0] w_sample_next;
    logic                r_valid;

    logic                w_any;
    logic                w_tick;
    logic [1:0]          w_note_enc;
    logic                w_run;
    logic                w_tone;
    logic [16:0]         w_sum;
    logic                w_att_full;
    logic [15:0]         w_amp_att;
    logic                w_rel_empty;
    logic [15:0]         w_amp_rel;
    logic [15:0]         w_neg_amp;

    assign w_any      = |bus.buttons;
    assign w_tick     = bus.sample_tick;
    assign w_note_enc = note_encode(bus.buttons);
    assign w_run      = (r_state != ST_IDLE);

    // Attack sum is one bit wider so it cannot wrap before the clamp.
    assign w_sum       = {1'b0, r_amp} + {1'b0, ATTACK_STEP};
    assign w_att_full  = (w_sum >= {1'b0, AMP_MAX});
    assign w_amp_att   = w_att_full ? AMP_MAX : w_sum[15:0];
    assign w_rel_empty = (r_amp <= RELEASE_STEP);
    assign w_amp_rel   = w_rel_empty ? 16'd0 : (r_amp - RELEASE_STEP);
    assign w_neg_amp   = ~r_amp + 16'd1;

    assign bus.audio_sample = r_sample;
    assign bus.sample_valid = r_valid;
    assign bus.busy         = r_busy;

    note_tone_osc #(
        .HALF_PERIODS (HALF_PERIODS)
    ) u_osc (
        .clk     (clk),
        .reset_n (reset_n),
        .i_note  (r_note),
        .i_run   (w_run),
        .o_tone  (w_tone)
    );

    // Note register follows the encoder while a button is held, else holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_note <= 2'd0;
        end else if (w_any) begin
            r_note <= w_note_enc;
        end else begin
            r_note <= r_note;
        end
    end

    // Envelope next state and amplitude; the amp update uses the current state.
    always_comb begin
        w_state_next = r_state;
        w_amp_next   = r_amp;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next = ST_ATTACK;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ATTACK: begin
                if (w_tick) begin
                    w_amp_next = w_amp_att;
                end else begin
                    w_amp_next = r_amp;
                end
                if (!w_any) begin
                    w_state_next = ST_RELEASE;
                end else if (w_tick && w_att_full) begin
                    w_state_next = ST_SUSTAIN;
                end else begin
                    w_state_next = ST_ATTACK;
                end
            end
            ST_SUSTAIN: begin
                if (!w_any) begin
                    w_state_next = ST_RELEASE;
                end else begin
                    w_state_next = ST_SUSTAIN;
                end
            end
            ST_RELEASE: begin
                if (w_tick) begin
                    w_amp_next = w_amp_rel;
                end else begin
                    w_amp_next = r_amp;
                end
                // Retrigger keeps the current amplitude.
                if (w_any) begin
                    w_state_next = ST_ATTACK;
                end else if (w_tick && w_rel_empty) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RELEASE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_amp_next   = 16'd0;
            end
        endcase
    end

    // Envelope state, amplitude and busy flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_amp   <= 16'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_amp   <= w_amp_next;
            r_busy  <= (w_state_next != ST_IDLE);
        end
    end

    // Next sample from the pre-update amp and tone; holds between ticks.
    always_comb begin
        w_sample_next = r_sample;
        if (!w_tick) begin
            w_sample_next = r_sample;
        end else if (r_state == ST_IDLE) begin
            w_sample_next = {SAMPLE_W{1'b0}};
        end else if (w_tone) begin
            w_sample_next = r_amp;
        end else begin
            w_sample_next = w_neg_amp;
        end
    end

    // Output sample and valid strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample <= {SAMPLE_W{1'b0}};
            r_valid  <= 1'b0;
        end else begin
            r_sample <= w_sample_next;
            r_valid  <= w_tick;
        end
    end

endmodule
